sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO: the synchronous, generalised successor of the team's asynchronous FIFO. Width, depth and almost-full/almost-empty thresholds are configurable. It also provides an occupancy count, sticky overflow/underflow error flags and an optional first-word-fall-through read mode. It is the default buffering element between same-clock pipeline stages and the DUT for the next class-based bench (generator/driver/monitor/scoreboard).

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16 words by default)
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wdata  in  DATA_WIDTH  write data, sampled when a write is accepted
- rd_en  in  1  read request (pop)
- rdata  out  DATA_WIDTH  read data
- rvalid  out  1  rdata holds a freshly popped (standard mode) or head (FWFT mode) word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty
- clr_err  in  1  clears overflow and underflow

## Operation
- Storage: DEPTH x DATA_WIDTH register array, not reset.
- Pointers: wptr and rptr, each ADDR_WIDTH+1 bits; the low bits address the array and the MSB is the wrap bit.
- Flag and count derivation:
  - count = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
  - full: MSBs differ and low bits are equal.
  - empty: pointers are equal.
- All flags and count are derived from registered pointers only; there is no combinational path from wr_en or rd_en to any flag.
- Write accepted = wr_en && !full. On acceptance, mem[wptr] <= wdata and wptr increments, wrapping naturally.
- Read accepted = rd_en && !empty. On acceptance, rptr increments.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both are accepted and count is unchanged.
  - Full: the read is accepted and the write is rejected (overflow sets).
  - Empty: the write is accepted and the read is rejected (underflow sets).
- Rejected requests never modify the pointers or the array.
- overflow sets on wr_en && full; underflow sets on rd_en && empty. Both stay high until clr_err. If a set and clr_err occur in the same cycle, the set wins.
- Reset (synchronous, mid-operation included): the FIFO drops all contents and restores every output to its reset value on the next edge. Any wr_en or rd_en in the reset cycle is ignored.
- Reset values:
  - wptr = rptr = 0, count = 0
  - empty = 1, full = 0
  - almost_empty = 1, almost_full = 0
  - rdata = 0, rvalid = 0
  - overflow = 0, underflow = 0

## Timing
- Flags and count update in the cycle after the accepted operation.
- A write into an empty FIFO deasserts empty one cycle later.
- A read at count == 1 asserts empty one cycle later.
- Standard mode:
  - rdata is registered. The word at the old rptr appears 1 cycle after an accepted read, with rvalid high for exactly that cycle.
  - rdata holds its value until the next accepted read.
  - Read latency is 1 cycle; write-to-readable latency is 1 cycle (empty low).
- Back-to-back operation: the FIFO sustains one write plus one read per cycle indefinitely, with no bubbles, across pointer wrap.

## Configuration
- FIFO_FWFT_EN:
  - Defined: first-word-fall-through mode. rdata = mem[rptr] combinationally whenever !empty and rvalid = !empty. rd_en acknowledges (pops) the displayed word, and the next word appears the following cycle. A word written into an empty FIFO becomes visible on rdata 1 cycle after the write. When empty, rdata is don't-care and the bench checks it only when rvalid = 1.
  - Undefined: standard registered-read mode as described above.
- Flags, count and error behaviour are identical in both modes.

## Test plan
All scenarios use default parameters (8-bit, depth 16, AF_LEVEL 14, AE_LEVEL 2).
- Reset then idle: all outputs equal their reset values; count = 0; empty = 1, almost_empty = 1.
- Fill: write 0x00..0x0F on 16 consecutive cycles. Required: almost_empty deasserts once count is 3, almost_full rises once count is 14, full rises once count is 16. A 17th write of 0xAA sets overflow and count stays 16. Draining 16 words returns 0x00..0x0F in order; empty = 1 after the last read. One more rd_en sets underflow.
- Simultaneous at the boundaries:
  - At full with wr_en = rd_en = 1: count becomes 15 and overflow = 1.
  - At empty with both asserted: count becomes 1, underflow = 1, and the next read returns the written word.
- Wrap: run 40 cycles of concurrent write/read with count held at 5. The data sequence is preserved across the pointer wrap and count stays 5 throughout.
- Errors and reset:
  - clr_err in the same cycle as a new overflow leaves overflow = 1; clr_err alone clears it.
  - Asserting rst with count = 9 gives count = 0 and empty = 1 next cycle, with all flags at their reset values.
- Read timing:
  - Standard mode: the first read after writing 0x5C gives rdata = 0x5C with rvalid pulsed 1 cycle later.
  - FIFO_FWFT_EN defined: 0x5C is visible on rdata with rvalid = 1 one cycle after the write, before any rd_en.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, threshold flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise rdata is registered on each pop.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = (32'sd1 << ADDR_WIDTH) - 32'sd2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);
    localparam int DEPTH = 32'sd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_THRESH = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH:0]   wptr_r;
    logic [ADDR_WIDTH:0]   rptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH:0]   wptr_nxt_s;
    logic [ADDR_WIDTH:0]   rptr_nxt_s;
    logic [ADDR_WIDTH:0]   count_nxt_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  almost_full_r;
    logic                  almost_empty_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  wr_acc_s;
    logic                  rd_acc_s;

    // Accept decisions and next-pointer computation; full/empty come from registered state only.
    always_comb begin
        wr_acc_s = wr_en && !full_r;
        rd_acc_s = rd_en && !empty_r;
        if (wr_acc_s) begin
            wptr_nxt_s = wptr_r + PTR_ONE;
        end else begin
            wptr_nxt_s = wptr_r;
        end
        if (rd_acc_s) begin
            rptr_nxt_s = rptr_r + PTR_ONE;
        end else begin
            rptr_nxt_s = rptr_r;
        end
        count_nxt_s = wptr_nxt_s - rptr_nxt_s;
    end

    // Pointers, flags and sticky errors; flags are pre-decoded from next pointers so outputs are flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r         <= {(ADDR_WIDTH + 1){1'b0}};
            rptr_r         <= {(ADDR_WIDTH + 1){1'b0}};
            count_r        <= {(ADDR_WIDTH + 1){1'b0}};
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            wptr_r         <= wptr_nxt_s;
            rptr_r         <= rptr_nxt_s;
            count_r        <= count_nxt_s;
            full_r         <= (wptr_nxt_s[ADDR_WIDTH] != rptr_nxt_s[ADDR_WIDTH]) &&
                              (wptr_nxt_s[ADDR_WIDTH-1:0] == rptr_nxt_s[ADDR_WIDTH-1:0]);
            empty_r        <= (wptr_nxt_s == rptr_nxt_s);
            almost_full_r  <= (count_nxt_s >= AF_THRESH);
            almost_empty_r <= (count_nxt_s <= AE_THRESH);
            // A new error event in the same cycle as clr_err keeps the flag set
            overflow_r     <= (wr_en && full_r) || (overflow_r && !clr_err);
            underflow_r    <= (rd_en && empty_r) || (underflow_r && !clr_err);
        end
    end

    // Storage array, deliberately without reset; writes in the reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !rst) begin
            mem_r[wptr_r[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

`ifdef FIFO_FWFT_EN
    logic [DATA_WIDTH-1:0] rdata_s;

    // Head word shown directly; forced to zero while empty so the output is defined after reset.
    always_comb begin
        if (empty_r) begin
            rdata_s = {DATA_WIDTH{1'b0}};
        end else begin
            rdata_s = mem_r[rptr_r[ADDR_WIDTH-1:0]];
        end
    end

    assign rdata  = rdata_s;
    assign rvalid = !empty_r;
`else
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  rvalid_r;

    // Registered read port: popped word appears one cycle after the accepted read and is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r  <= {DATA_WIDTH{1'b0}};
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= rd_acc_s;
            if (rd_acc_s) begin
                rdata_r <= mem_r[rptr_r[ADDR_WIDTH-1:0]];
            end
        end
    end

    assign rdata  = rdata_r;
    assign rvalid = rvalid_r;
`endif

    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed scenarios then random traffic against a queue model.
module tb_sync_fifo_param;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wdata;
    logic       rd_en;
    logic [7:0] rdata;
    logic       rvalid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: content queue, sticky errors, last popped word.
    logic [7:0] q[$];
    logic       m_ovf;
    logic       m_unf;
    logic [7:0] m_rdata;
    logic       m_rvalid;

    sync_fifo_param dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, "/count"},        32'(count),        32'(n));
        chk({tag, "/empty"},        32'(empty),        32'(n == 0));
        chk({tag, "/full"},         32'(full),         32'(n == DEPTH));
        chk({tag, "/almost_full"},  32'(almost_full),  32'(n >= AF));
        chk({tag, "/almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        chk({tag, "/overflow"},     32'(overflow),     32'(m_ovf));
        chk({tag, "/underflow"},    32'(underflow),    32'(m_unf));
`ifdef FIFO_FWFT_EN
        chk({tag, "/rvalid"}, 32'(rvalid), 32'(n != 0));
        if (n != 0) begin
            chk({tag, "/rdata"}, 32'(rdata), 32'(q[0]));
        end
`else
        chk({tag, "/rvalid"}, 32'(rvalid), 32'(m_rvalid));
        chk({tag, "/rdata"},  32'(rdata),  32'(m_rdata));
`endif
    endtask

    // One clock: drive inputs, advance the model by the FIFO's rules, compare every output.
    task automatic cycle(input logic r, input logic w, input logic [7:0] d,
                         input logic rd, input logic c, input string tag);
        logic was_full;
        logic was_empty;
        rst     = r;
        wr_en   = w;
        wdata   = d;
        rd_en   = rd;
        clr_err = c;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            m_rdata  = 8'h00;
            m_rvalid = 1'b0;
        end else begin
            m_rvalid = 1'b0;
            if (rd && !was_empty) begin
                m_rdata  = q.pop_front();
                m_rvalid = 1'b1;
            end
            if (w && !was_full) begin
                q.push_back(d);
            end
            m_ovf = (w && was_full) || (m_ovf && !c);
            m_unf = (rd && was_empty) || (m_unf && !c);
        end
        check_all(tag);
    endtask

    initial begin
        // Reset, including requests during reset that must be ignored
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, "reset");
        cycle(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, "reset_busy");
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "idle");

        // Fill 0x00..0x0F, overflow write, drain, underflow read
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, "fill");
        cycle(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, "overflow_write");
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "drain");
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "underflow_read");
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "clr_err");

        // Simultaneous write/read at full
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0, "fill2");
        cycle(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, "full_wr_rd");
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "clr_after_full");
        cycle(1'b0, 1'b1, 8'h66, 1'b0, 1'b0, "refill");

        // clr_err racing a new overflow, then clr_err alone
        cycle(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, "ovf_vs_clr");
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "clr_only");

        // Simultaneous write/read at empty
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "drain2");
        cycle(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, "empty_wr_rd");
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "read_after_empty_wr");
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "clr2");

        // Wrap: hold count at 5 with concurrent traffic
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0, "prime5");
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0, "wrap");

        // Reset with count 9, mid-operation
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0, "to9");
        cycle(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, "overflow_probe_skip");
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "back_to9");
        cycle(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, "reset_at_9");

        // Read timing for a single word
        cycle(1'b0, 1'b1, 8'h5C, 1'b0, 1'b0, "write_5c");
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "idle_5c");
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "read_5c");
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "hold_5c");

        // Random traffic with occasional clears and resets
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 99) < 55),
                  8'($urandom),
                  ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 15) == 0),
                  "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
